// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Types shared by the convolution device controller and its operand streamer.
//   stream_state_t : operand streamer FSM states
//   loop_idx_t     : one position of the x / y / ch_in / ch_out / k_v / k_h
//                    loop nest, 32 bits per index
//   wrap_inc()     : advance one loop index, wrapping to 0 after its last value
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int unsigned IDX_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } stream_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] x;
        logic [IDX_W-1:0] y;
        logic [IDX_W-1:0] ch_in;
        logic [IDX_W-1:0] ch_out;
        logic [IDX_W-1:0] k_v;
        logic [IDX_W-1:0] k_h;
    } loop_idx_t;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] value,
                                                  input logic [IDX_W-1:0] last);
        return (value == last) ? '0 : value + 1'b1;
    endfunction

endpackage

// File: rtl/operand_skid_buffer.sv
// -----------------------------------------------------------------------------
// operand_skid_buffer
// Two-entry FIFO holding {activation, weight} operand pairs between the memory
// read return and the a/b valid/ready interface.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i this cycle (caller guarantees not full)
//   push_data_i   : operand pair to store
//   pop_i         : drop the head entry this cycle (caller guarantees not empty)
//   head_o        : oldest stored entry (all zeros after reset)
//   count_o       : occupancy, 0..2
// -----------------------------------------------------------------------------
module operand_skid_buffer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            if (wr_ptr_q) begin
                ent1_d = push_data_i;
            end else begin
                ent0_d = push_data_i;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = rd_ptr_q ? ent1_q : ent0_q;
    assign count_o = count_q;

endmodule

// File: rtl/conv_operand_streamer.sv
// -----------------------------------------------------------------------------
// conv_operand_streamer
// Walks the x / y / ch_in / ch_out / k_v / k_h loop nest, reads the matching
// activation and weight words from two single-port memories (1-cycle read
// latency) and presents them on the a/b operand interface.
//   clk, arst_n_in        : clock, asynchronous active-low reset
//   start                 : one-cycle pulse, starts a pass when idle
//   busy, done            : pass in progress / one-cycle end-of-pass pulse
//   act_re, act_addr      : activation read (low at feature-map padding taps)
//   wgt_re, wgt_addr      : weight read (high on every issue)
//   act_rdata, wgt_rdata  : read data, one cycle after the read enable
//   a_valid/a_ready/a_data, b_valid/b_ready/b_data : operand outputs
//   dbg_state_o           : FSM state
//   dbg_count_o           : skid buffer occupancy
//
// Handshake: a_valid and b_valid are always equal. A transfer happens in a
// cycle where a_valid && b_valid && a_ready && b_ready; ready on one side only
// transfers nothing. While valid is high and no transfer occurs, valid and
// data stay unchanged.
// -----------------------------------------------------------------------------
module conv_operand_streamer
    import conv_pkg::*;
#(
    parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
    parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
    parameter int unsigned INPUT_NB_CHANNELS  = 64,
    parameter int unsigned OUTPUT_NB_CHANNELS = 64,
    parameter int unsigned KERNEL_SIZE        = 3,
    parameter int unsigned IO_DATA_WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH         = 32
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     act_re,
    output logic                     wgt_re,
    output logic [ADDR_WIDTH-1:0]    act_addr,
    output logic [ADDR_WIDTH-1:0]    wgt_addr,
    input  logic [IO_DATA_WIDTH-1:0] act_rdata,
    input  logic [IO_DATA_WIDTH-1:0] wgt_rdata,
    output logic                     a_valid,
    output logic                     b_valid,
    input  logic                     a_ready,
    input  logic                     b_ready,
    output logic [IO_DATA_WIDTH-1:0] a_data,
    output logic [IO_DATA_WIDTH-1:0] b_data,
    output stream_state_t            dbg_state_o,
    output logic [1:0]               dbg_count_o
);

    localparam logic [IDX_W-1:0] X_LAST  = IDX_W'(FEATURE_MAP_WIDTH - 1);
    localparam logic [IDX_W-1:0] Y_LAST  = IDX_W'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [IDX_W-1:0] CI_LAST = IDX_W'(INPUT_NB_CHANNELS - 1);
    localparam logic [IDX_W-1:0] CO_LAST = IDX_W'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(KERNEL_SIZE - 1);

    localparam logic signed [IDX_W:0] HALF_K = (IDX_W + 1)'(KERNEL_SIZE / 2);
    localparam logic signed [IDX_W:0] MAP_W  = (IDX_W + 1)'(FEATURE_MAP_WIDTH);
    localparam logic signed [IDX_W:0] MAP_H  = (IDX_W + 1)'(FEATURE_MAP_HEIGHT);

    localparam logic [ADDR_WIDTH-1:0] A_W   = ADDR_WIDTH'(FEATURE_MAP_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] A_CIN = ADDR_WIDTH'(INPUT_NB_CHANNELS);
    localparam logic [ADDR_WIDTH-1:0] A_K   = ADDR_WIDTH'(KERNEL_SIZE);

    stream_state_t state_q, state_d;
    loop_idx_t     idx_q, idx_d;
    logic          inflight_q;  // a read was issued last cycle; data returns now
    logic          pad_q;       // that read was a padding tap

    logic          issue;
    logic          pop;
    logic [1:0]    buf_count;
    logic [2*IO_DATA_WIDTH-1:0] buf_head;
    logic [2*IO_DATA_WIDTH-1:0] push_data;

    logic signed [IDX_W:0] xi, yi;
    logic                  in_bounds;
    logic [ADDR_WIDTH-1:0] xu, yu;
    logic [ADDR_WIDTH-1:0] act_addr_c, wgt_addr_c;

    logic last_x, last_y, last_ci, last_co, last_kv, last_kh;
    logic c_kv, c_co, c_ci, c_y, c_x, last_tap;

    // ---------------------------------------------------------------------
    // Tap position and addresses
    // ---------------------------------------------------------------------
    always_comb begin
        xi = $signed({1'b0, idx_q.x}) + $signed({1'b0, idx_q.k_h}) - HALF_K;
        yi = $signed({1'b0, idx_q.y}) + $signed({1'b0, idx_q.k_v}) - HALF_K;
        in_bounds = !xi[IDX_W] && !yi[IDX_W] && (xi < MAP_W) && (yi < MAP_H);
        xu = ADDR_WIDTH'(xi[IDX_W-1:0]);
        yu = ADDR_WIDTH'(yi[IDX_W-1:0]);
        act_addr_c = (yu * A_W + xu) * A_CIN + ADDR_WIDTH'(idx_q.ch_in);
        wgt_addr_c = ((ADDR_WIDTH'(idx_q.ch_out) * A_CIN + ADDR_WIDTH'(idx_q.ch_in)) * A_K
                      + ADDR_WIDTH'(idx_q.k_v)) * A_K + ADDR_WIDTH'(idx_q.k_h);
    end

    // ---------------------------------------------------------------------
    // Issue control. The space check uses the occupancy after this cycle's
    // pop so that a steady stream issues every cycle; it keeps
    // occupancy + reads in flight <= 2, so the buffer can never overflow.
    // ---------------------------------------------------------------------
    assign pop   = a_valid && b_valid && a_ready && b_ready;
    assign issue = (state_q == STREAM) &&
                   (({1'b0, buf_count} - {2'b00, pop} + {2'b00, inflight_q}) < 3'd2);

    assign act_re   = issue && in_bounds;
    assign wgt_re   = issue;
    assign act_addr = act_re ? act_addr_c : '0;
    assign wgt_addr = wgt_re ? wgt_addr_c : '0;

    // ---------------------------------------------------------------------
    // Loop nest counters: k_h innermost, x outermost. c_* is the carry into
    // each counter (all inner counters at their last value).
    // ---------------------------------------------------------------------
    always_comb begin
        last_x   = (idx_q.x == X_LAST);
        last_y   = (idx_q.y == Y_LAST);
        last_ci  = (idx_q.ch_in == CI_LAST);
        last_co  = (idx_q.ch_out == CO_LAST);
        last_kv  = (idx_q.k_v == K_LAST);
        last_kh  = (idx_q.k_h == K_LAST);
        c_kv     = last_kh;
        c_co     = c_kv && last_kv;
        c_ci     = c_co && last_co;
        c_y      = c_ci && last_ci;
        c_x      = c_y && last_y;
        last_tap = c_x && last_x;

        idx_d = idx_q;
        if (state_q == IDLE && start) begin
            idx_d = '0;
        end else if (issue) begin
            idx_d.k_h = wrap_inc(idx_q.k_h, K_LAST);
            if (c_kv) idx_d.k_v    = wrap_inc(idx_q.k_v, K_LAST);
            if (c_co) idx_d.ch_out = wrap_inc(idx_q.ch_out, CO_LAST);
            if (c_ci) idx_d.ch_in  = wrap_inc(idx_q.ch_in, CI_LAST);
            if (c_y)  idx_d.y      = wrap_inc(idx_q.y, Y_LAST);
            if (c_x)  idx_d.x      = wrap_inc(idx_q.x, X_LAST);
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = STREAM;
            end
            STREAM: begin
                if (issue && last_tap) state_d = DRAIN;
            end
            DRAIN: begin
                if (buf_count == 2'd0 && !inflight_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            inflight_q <= 1'b0;
            pad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            inflight_q <= issue;
            pad_q      <= issue && !in_bounds;
        end
    end

    // ---------------------------------------------------------------------
    // Returning read data goes straight into the skid buffer; padding taps
    // replace whatever the activation memory drives with zero.
    // ---------------------------------------------------------------------
    assign push_data = {(pad_q ? '0 : act_rdata), wgt_rdata};

    operand_skid_buffer #(
        .DATA_W (2 * IO_DATA_WIDTH)
    ) u_skid (
        .clk_i       (clk),
        .rst_ni      (arst_n_in),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (buf_head),
        .count_o     (buf_count)
    );

    assign a_valid     = (buf_count != 2'd0);
    assign b_valid     = (buf_count != 2'd0);
    assign a_data      = buf_head[2*IO_DATA_WIDTH-1:IO_DATA_WIDTH];
    assign b_data      = buf_head[IO_DATA_WIDTH-1:0];
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;
    assign dbg_count_o = buf_count;

endmodule

// File: tb/tb_conv_operand_streamer.sv
module tb_conv_operand_streamer;

    localparam int W     = 3;
    localparam int H     = 3;
    localparam int CIN   = 2;
    localparam int COUT  = 2;
    localparam int K     = 3;
    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int NXFER = W * H * CIN * COUT * K * K;

    logic          clk;
    logic          arst_n_in;
    logic          start;
    logic          busy;
    logic          done;
    logic          act_re;
    logic          wgt_re;
    logic [AW-1:0] act_addr;
    logic [AW-1:0] wgt_addr;
    logic [DW-1:0] act_rdata;
    logic [DW-1:0] wgt_rdata;
    logic          a_valid;
    logic          b_valid;
    logic          a_ready;
    logic          b_ready;
    logic [DW-1:0] a_data;
    logic [DW-1:0] b_data;
    conv_pkg::stream_state_t dbg_state;
    logic [1:0]    dbg_count;

    conv_operand_streamer #(
        .FEATURE_MAP_WIDTH  (W),
        .FEATURE_MAP_HEIGHT (H),
        .INPUT_NB_CHANNELS  (CIN),
        .OUTPUT_NB_CHANNELS (COUT),
        .KERNEL_SIZE        (K),
        .IO_DATA_WIDTH      (DW),
        .ADDR_WIDTH         (AW)
    ) dut (
        .clk         (clk),
        .arst_n_in   (arst_n_in),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .act_re      (act_re),
        .wgt_re      (wgt_re),
        .act_addr    (act_addr),
        .wgt_addr    (wgt_addr),
        .act_rdata   (act_rdata),
        .wgt_rdata   (wgt_rdata),
        .a_valid     (a_valid),
        .b_valid     (b_valid),
        .a_ready     (a_ready),
        .b_ready     (b_ready),
        .a_data      (a_data),
        .b_data      (b_data),
        .dbg_state_o (dbg_state),
        .dbg_count_o (dbg_count)
    );

    // ---------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------
    // Memory contents: distinct non-zero words so padding zeros are
    // distinguishable from real data.
    // ---------------------------------------------------------------
    function automatic logic [DW-1:0] act_word(input logic [31:0] addr);
        return DW'(addr * 32'd7 + 32'd1);
    endfunction

    function automatic logic [DW-1:0] wgt_word(input logic [31:0] addr);
        return DW'(addr * 32'd3 + 32'h100);
    endfunction

    // Single-port memories, one-cycle read latency; garbage when not read.
    always @(posedge clk) begin
        act_rdata <= act_re ? act_word(act_addr) : DW'($urandom);
        wgt_rdata <= wgt_re ? wgt_word(wgt_addr) : DW'($urandom);
    end

    // ---------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    logic [2*DW-1:0] exp_q[$];

    int   xfer_cnt;
    int   first_valid_cyc;
    int   last_xfer_cyc;
    int   done_cnt;
    int   done_cyc;
    int   iss_n;
    logic rec;
    logic prev_hold;
    logic [2*DW-1:0] prev_data;

    logic            rec_act_re   [NXFER];
    logic [AW-1:0]   rec_act_addr [NXFER];
    logic [AW-1:0]   rec_wgt_addr [NXFER];
    logic [2*DW-1:0] rec_data     [NXFER];

    typedef struct {
        int            n;
        logic          act_re;
        logic [AW-1:0] act_addr;
        logic [AW-1:0] wgt_addr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } tap_vec_t;

    tap_vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference stream: plain loop nest over the operand definition.
    task automatic build_model();
        exp_q.delete();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                for (int ci = 0; ci < CIN; ci++)
                    for (int co = 0; co < COUT; co++)
                        for (int kv = 0; kv < K; kv++)
                            for (int kh = 0; kh < K; kh++) begin
                                int xi;
                                int yi;
                                logic [DW-1:0] a;
                                logic [DW-1:0] b;
                                xi = x + kh - K / 2;
                                yi = y + kv - K / 2;
                                if (xi >= 0 && xi < W && yi >= 0 && yi < H)
                                    a = act_word(32'((yi * W + xi) * CIN + ci));
                                else
                                    a = '0;
                                b = wgt_word(32'(((co * CIN + ci) * K + kv) * K + kh));
                                exp_q.push_back({a, b});
                            end
    endtask

    task automatic begin_pass(input logic rec_en);
        build_model();
        xfer_cnt        = 0;
        first_valid_cyc = -1;
        last_xfer_cyc   = -1;
        done_cnt        = 0;
        done_cyc        = -1;
        iss_n           = 0;
        rec             = rec_en;
        prev_hold       = 1'b0;
    endtask

    // Samples outputs at the falling edge, with the inputs that the next
    // rising edge will see.
    task automatic monitor();
        if (arst_n_in) begin
            if (prev_hold)
                check("hold_stable", {a_valid, b_valid, a_data, b_data}, {2'b11, prev_data});
            prev_hold = a_valid && !(a_ready && b_ready);
            prev_data = {a_data, b_data};
        end else begin
            prev_hold = 1'b0;
        end
        if (a_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (a_valid && b_valid && a_ready && b_ready) begin
            if (rec && xfer_cnt < NXFER) rec_data[xfer_cnt] = {a_data, b_data};
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL extra_xfer: got %0h expected no transfer (cycle %0d)",
                         {a_data, b_data}, cyc);
            end else begin
                check($sformatf("xfer_data[%0d]", xfer_cnt), {a_data, b_data}, exp_q.pop_front());
            end
            xfer_cnt++;
            last_xfer_cyc = cyc;
        end
        if (wgt_re) begin
            if (rec && iss_n < NXFER) begin
                rec_act_re[iss_n]   = act_re;
                rec_act_addr[iss_n] = act_addr;
                rec_wgt_addr[iss_n] = wgt_addr;
            end
            iss_n++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_start(output int sc);
        start = 1'b1;
        sc = cyc;
        cycle();
        start = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: random 50% ready, a_ready == b_ready.
    task automatic run_to_done(input int mode, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (mode == 0) begin
                a_ready = 1'b1;
            end else begin
                a_ready = 1'($urandom_range(0, 1));
            end
            b_ready = a_ready;
            cycle();
            if (done_cnt > 0) break;
        end
        cycle();
        check("done_count", 64'(done_cnt), 64'd1);
    endtask

    task automatic end_pass_checks(input string tag);
        check({tag, "_xfer_count"}, 64'(xfer_cnt), 64'(NXFER));
        check({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_xfer_cyc + 1));
        check({tag, "_idle"}, {busy, done, dbg_state}, {2'b00, conv_pkg::IDLE});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {busy, done, act_re, wgt_re, a_valid, b_valid, dbg_count, dbg_state}, 64'd0);
        check({tag, "_data"}, {a_data, b_data}, 64'd0);
        check({tag, "_addr"}, {act_addr, wgt_addr}, 64'd0);
    endtask

    // ---------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------
    initial begin
        int sc;
        int x0;
        int i0;

        tbl[0] = '{0,   1'b0, 32'd0, 32'd0,  16'd0,       wgt_word(0)};
        tbl[1] = '{1,   1'b0, 32'd0, 32'd1,  16'd0,       wgt_word(1)};
        tbl[2] = '{4,   1'b1, 32'd0, 32'd4,  act_word(0), wgt_word(4)};
        tbl[3] = '{13,  1'b1, 32'd0, 32'd22, act_word(0), wgt_word(22)};
        tbl[4] = '{100, 1'b1, 32'd7, 32'd28, act_word(7), wgt_word(28)};
        tbl[5] = '{166, 1'b1, 32'd9, 32'd13, act_word(9), wgt_word(13)};
        tbl[6] = '{323, 1'b0, 32'd0, 32'd35, 16'd0,       wgt_word(35)};

        arst_n_in = 1'b0;
        start     = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        begin_pass(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        arst_n_in = 1'b1;
        cycle();
        cycle();

        // Pass 1: ready always high, record issues and transfers.
        begin_pass(1'b1);
        a_ready = 1'b1;
        b_ready = 1'b1;
        do_start(sc);
        run_to_done(0, 1000);
        end_pass_checks("p1");
        check("p1_first_valid_latency", 64'(first_valid_cyc - sc), 64'd3);
        check("p1_throughput", 64'(last_xfer_cyc - first_valid_cyc), 64'(NXFER - 1));
        check("p1_issue_count", 64'(iss_n), 64'(NXFER));
        for (int t = 0; t < 7; t++) begin
            check($sformatf("tap%0d_act_re", tbl[t].n), 64'(rec_act_re[tbl[t].n]), 64'(tbl[t].act_re));
            check($sformatf("tap%0d_act_addr", tbl[t].n), 64'(rec_act_addr[tbl[t].n]), 64'(tbl[t].act_addr));
            check($sformatf("tap%0d_wgt_addr", tbl[t].n), 64'(rec_wgt_addr[tbl[t].n]), 64'(tbl[t].wgt_addr));
            check($sformatf("tap%0d_data", tbl[t].n), 64'(rec_data[tbl[t].n]), 64'({tbl[t].a, tbl[t].b}));
        end

        // Pass 2: random backpressure; start during busy must be ignored.
        begin_pass(1'b0);
        do_start(sc);
        start = 1'b1;
        cycle();
        start = 1'b0;
        run_to_done(1, 4000);
        end_pass_checks("p2");

        // Pass 3: ready on one side only stalls everything.
        begin_pass(1'b0);
        a_ready = 1'b1;
        b_ready = 1'b1;
        do_start(sc);
        repeat (20) cycle();
        a_ready = 1'b1;
        b_ready = 1'b0;
        x0 = xfer_cnt;
        repeat (3) cycle();
        i0 = iss_n;
        repeat (7) cycle();
        check("stall_no_xfer", 64'(xfer_cnt), 64'(x0));
        check("stall_no_issue", 64'(iss_n), 64'(i0));
        check("stall_occupancy", 64'(dbg_count), 64'd2);
        check("stall_re", {act_re, wgt_re}, 64'd0);
        check("stall_valid", {a_valid, b_valid}, 64'd3);
        run_to_done(0, 1000);
        end_pass_checks("p3");

        // Pass 4: reset after 50 transfers.
        begin_pass(1'b0);
        a_ready = 1'b1;
        b_ready = 1'b1;
        do_start(sc);
        for (int i = 0; i < 200; i++) begin
            if (xfer_cnt >= 50) break;
            cycle();
        end
        check("p4_xfers_before_reset", 64'(xfer_cnt), 64'd50);
        arst_n_in = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        cycle();
        check_reset_outputs("reset_held");
        arst_n_in = 1'b1;
        cycle();

        // Pass 5: full pass after the mid-pass reset.
        begin_pass(1'b0);
        do_start(sc);
        run_to_done(0, 1000);
        end_pass_checks("p5");
        check("p5_first_valid_latency", 64'(first_valid_cyc - sc), 64'd3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
